// File: rtl/mux_sel_reg_if.sv
`default_nettype none
// ============================================================================
// Module   : mux_sel_reg_if
// Brief    : Handshake/bus bundle for the registered N-to-1 selector.
// Revision : 1.0
// ============================================================================
interface mux_sel_reg_if #(
    parameter int WIDTH = 8,
    parameter int N     = 3,
    parameter int SEL_W = 2
);
    logic [N*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]   sel;
    logic               mode;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   out_data;
    logic [SEL_W-1:0]   out_sel;
    logic               out_valid;
    logic               out_ready;
    logic [SEL_W-1:0]   ptr;
    logic               err;

    modport master (
        output in_data, sel, mode, in_valid, out_ready,
        input  in_ready, out_data, out_sel, out_valid, ptr, err
    );

    modport slave (
        input  in_data, sel, mode, in_valid, out_ready,
        output in_ready, out_data, out_sel, out_valid, ptr, err
    );
endinterface
`default_nettype wire

// File: rtl/mux_sel_reg.sv
`default_nettype none
// ============================================================================
// Module   : mux_sel_reg
// Brief    : N-to-1 selector (explicit or round-robin) into one valid/ready
//            output register with a sticky out-of-range select flag.
// Revision : 1.0
// ============================================================================
module mux_sel_reg #(
    parameter int WIDTH = 8,
    parameter int N     = 3,
    parameter int SEL_W = 2
) (
    input  logic         clk,
    input  logic         rst,
    mux_sel_reg_if.slave bus
);
    // One extra bit so N == 2**SEL_W still compares correctly.
    localparam logic [SEL_W:0]   c_N        = (SEL_W+1)'(N);
    localparam logic [SEL_W-1:0] c_LAST_CH  = SEL_W'(N-1);

    logic [WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0] r_out_sel;
    logic             r_out_valid;
    logic [SEL_W-1:0] r_ptr;
    logic             r_err;

    logic             w_in_ready;
    logic             w_accept;
    logic [SEL_W-1:0] w_ch;
    logic             w_in_range;
    logic [WIDTH-1:0] w_sel_data;
    logic [SEL_W-1:0] w_ptr_next;

    assign w_in_ready = !r_out_valid || bus.out_ready;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_ch       = bus.mode ? r_ptr : bus.sel;
    assign w_in_range = ({1'b0, w_ch} < c_N);
    assign w_ptr_next = (r_ptr == c_LAST_CH) ? '0 : r_ptr + SEL_W'(1);

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_ch == SEL_W'(i)) begin
                w_sel_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_out_valid <= 1'b0;
            r_ptr       <= '0;
            r_err       <= 1'b0;
        end else if (w_accept) begin
            if (w_in_range) begin
                r_out_data  <= w_sel_data;
                r_out_sel   <= w_ch;
                r_out_valid <= 1'b1;
            end else begin
                // Dropped beat: only the drain of the held beat can clear valid.
                r_err <= 1'b1;
                if (bus.out_ready) begin
                    r_out_valid <= 1'b0;
                end
            end
            if (bus.mode) begin
                r_ptr <= w_ptr_next;
            end
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_data  = r_out_data;
    assign bus.out_sel   = r_out_sel;
    assign bus.out_valid = r_out_valid;
    assign bus.ptr       = r_ptr;
    assign bus.err       = r_err;
endmodule
`default_nettype wire

// File: doc/mux_sel_reg.md
# mux_sel_reg

Parametrised N-to-1 selector with a registered, handshaked output stage, the successor to the fixed 8-bit 3:1 datapath mux in the processor core. It selects one of N WIDTH-bit channels either by an explicit select or by an internal rotating pointer. It holds the result in a single output register under valid/ready flow control. An out-of-range select is reported through a sticky error flag instead of halting simulation.

## Interface
- WIDTH, 8, data width of each channel and of the output
- N, 3, number of input channels; legal range N >= 2
- SEL_W, 2, select/pointer width; must satisfy 2^SEL_W >= N
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- in_data  input  N*WIDTH  packed channels; channel i at bits [i*WIDTH +: WIDTH]
- sel  input  SEL_W  explicit channel select; used only when mode=0
- mode  input  1  0 = explicit select, 1 = rotating (round-robin) select
- in_valid  input  1  upstream offers a beat
- in_ready  output  1  block can accept a beat this cycle
- out_data  output  WIDTH  registered selected data
- out_sel  output  SEL_W  channel index that produced out_data
- out_valid  output  1  out_data/out_sel hold a beat
- out_ready  input  1  downstream consumes the beat this cycle
- ptr  output  SEL_W  current rotating pointer
- err  output  1  sticky flag: an out-of-range select was accepted

## Operation
- Accept condition: in_valid && in_ready.
- in_ready = !out_valid || out_ready. This is combinational and gives a single-register pipeline with no bubble.
- Effective channel: ch = sel when mode=0; ch = ptr when mode=1.
- Valid accept with ch < N: out_data <= channel ch, out_sel <= ch, out_valid <= 1.
- Accept in mode=0 with sel >= N: the beat is consumed and dropped.
  - err <= 1.
  - out_data and out_sel are unchanged.
  - out_valid <= 0 if the held beat drained this cycle (out_ready=1); otherwise out_valid is unchanged.
- No accept this cycle and out_valid && out_ready: out_valid <= 0. out_data and out_sel keep their last values.
- ptr advances only on an accept in mode=1: ptr <= (ptr == N-1) ? 0 : ptr+1. In mode=0, ptr holds.
- Mode changes take effect on the next accept. ptr is not cleared by a mode change.
- err clears only on rst. sel is ignored in mode=1 and never raises err there.
- No combinational path from in_data or sel to out_data.

## Timing
- Reset values: out_data=0, out_sel=0, out_valid=0, ptr=0, err=0. in_ready=1 after reset because it follows out_valid=0.
- Reset mid-operation discards any held beat at the same edge. rst has priority over every other update.
- Latency: data accepted at edge k appears on out_data with out_valid=1 after edge k.
- Throughput: 1 beat/cycle while out_ready=1.
- Backpressure: while out_valid=1 and out_ready=0, in_ready=0 and out_data, out_sel and ptr are stable.
- Simultaneous drain and accept in the same cycle: the new beat replaces the old one, and out_valid stays 1.
- ptr wrap: N-1 -> 0 on the accept edge. With N=3 the sequence is 0,1,2,0.

## Test plan
- Reset, then explicit select: N=3, WIDTH=8, in_data={8'hC3,8'hB2,8'hA1}, mode=0, sel=1, in_valid=1, out_ready=1 for 1 cycle -> out_data=8'hB2, out_sel=1, out_valid=1 one cycle later, err=0.
- Rotate with wrap: mode=1, in_valid=1, out_ready=1 for 4 cycles -> out_data sequence A1,B2,C3,A1; out_sel 0,1,2,0; ptr returns to 1.
- Backpressure: hold out_ready=0 after one accept of 8'hA1 for 3 cycles -> in_ready=0, out_data stays 8'hA1, ptr frozen. Raise out_ready with in_valid=1 -> the next beat loads the same cycle and out_valid stays 1.
- Invalid select: mode=0, sel=3, in_valid=1, out_valid=0 -> beat dropped, err=1, out_valid=0. err stays 1 through later valid beats until rst.
- Mid-operation reset: out_valid=1 with out_data=8'hC3, ptr=2, err=1; assert rst for 1 cycle -> out_data=0, out_valid=0, ptr=0, err=0, in_ready=1.
- Mode switch: rotate to ptr=2, switch to mode=0 with sel=0, accept one beat -> out_data=8'hA1 and ptr stays 2. Return to mode=1 -> the next beat is channel 2 (8'hC3).
